// File: rtl/output_port_arbiter.sv
// Wormhole round-robin arbiter for one router output port. It grants the link to one input FIFO
// from head flit to tail flit and only sends a flit when the downstream buffer has a free credit.
module output_port_arbiter #(
    parameter  int RADIX   = 4,
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1),
    localparam int SW      = $clog2(RADIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RADIX-1:0] req_valid,
    input  logic [RADIX-1:0] req_tail,
    input  logic             credit_in,
    output logic [RADIX-1:0] fifo_re,
    output logic [SW-1:0]    sel,
    output logic             out_valid,
    output logic             busy,
    output logic [CW-1:0]    credits,
    output logic             credit_err
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] owner_q, owner_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] credits_q, credits_d;
    logic          err_q, err_d;

    logic [SW-1:0] winner;
    logic          xfer;

    // Round-robin scan: first requester at or above rr_ptr, wrapping modulo RADIX.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        winner = '0;
        for (int k = RADIX - 1; k >= 0; k--) begin
            logic [SW-1:0] idx;
            idx = SW'((int'(rr_ptr_q) + k) % RADIX);
            if (req_valid[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        xfer     = 1'b0;
        fifo_re  = '0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d = winner;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                xfer = req_valid[owner_q] && (credits_q != '0);
                if (xfer && req_tail[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == SW'(RADIX - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset suppresses any transfer in the same cycle, before the state register clears.
        if (rst) begin
            xfer = 1'b0;
        end
        if (xfer) begin
            fifo_re[owner_q] = 1'b1;
        end
    end

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (xfer && !credit_in) begin
            credits_d = credits_q - 1'b1;
        end else if (credit_in && !xfer) begin
            if (credits_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign out_valid  = xfer;
    assign sel        = owner_q;
    assign busy       = (state_q == LOCKED);
    assign credits    = credits_q;
    assign credit_err = err_q;

    a_re_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(fifo_re));
    a_re_credit  : assert property (@(posedge clk) disable iff (rst) (fifo_re != '0) |-> (credits_q != '0));
    a_cred_max   : assert property (@(posedge clk) credits_q <= CW'(CREDITS));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed scenarios plus a randomized phase,
// all compared against a packet-level reference model of the arbitration and credit rules.
module tb_output_port_arbiter;

    localparam int RADIX   = 4;
    localparam int CREDITS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_tail;
    logic       credit_in;
    logic [3:0] fifo_re;
    logic [1:0] sel;
    logic       out_valid;
    logic       busy;
    logic [2:0] credits;
    logic       credit_err;

    output_port_arbiter #(.RADIX(RADIX), .CREDITS(CREDITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tail  (req_tail),
        .credit_in (credit_in),
        .fifo_re   (fifo_re),
        .sel       (sel),
        .out_valid (out_valid),
        .busy      (busy),
        .credits   (credits),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the link, where the round-robin search starts, free credits.
    bit m_locked;
    int m_owner;
    int m_rr;
    int m_cred;
    bit m_err;

    int flits;
    int min_cred;
    bit busy_prev;
    bit last_ov;
    int grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nearest requester at or after the round-robin start, by circular distance.
    function automatic int pick(input logic [3:0] rv, input int start);
        int best  = -1;
        int bestd = RADIX;
        for (int i = 0; i < RADIX; i++) begin
            int d = (i - start + RADIX) % RADIX;
            if (rv[i] && d < bestd) begin
                best  = i;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic tick();
        bit         xfer;
        logic [3:0] exp_re;
        @(negedge clk);
        xfer   = !rst && m_locked && req_valid[m_owner] && (m_cred > 0);
        exp_re = xfer ? (4'b0001 << m_owner) : 4'b0000;
        check("fifo_re",    32'(fifo_re),    32'(exp_re));
        check("out_valid",  32'(out_valid),  32'(xfer));
        check("sel",        32'(sel),        32'(m_owner));
        check("busy",       32'(busy),       32'(m_locked));
        check("credits",    32'(credits),    32'(m_cred));
        check("credit_err", 32'(credit_err), 32'(m_err));
        if (out_valid) flits++;
        if (int'(credits) < min_cred) min_cred = int'(credits);
        if (busy && !busy_prev) grants.push_back(int'(sel));
        busy_prev = busy;
        last_ov   = out_valid;
        @(posedge clk);
        if (rst) begin
            m_locked = 1'b0;
            m_owner  = 0;
            m_rr     = 0;
            m_cred   = CREDITS;
            m_err    = 1'b0;
        end else begin
            if (xfer && !credit_in) m_cred--;
            else if (credit_in && !xfer) begin
                if (m_cred == CREDITS) m_err = 1'b1;
                else m_cred++;
            end
            if (!m_locked && |req_valid) begin
                m_owner  = pick(req_valid, m_rr);
                m_locked = 1'b1;
            end else if (xfer && req_tail[m_owner]) begin
                m_locked = 1'b0;
                m_rr     = (m_owner + 1) % RADIX;
            end
        end
        #1;
    endtask

    task automatic refill();
        req_valid = '0;
        req_tail  = '0;
        for (int i = 0; i < CREDITS && m_cred < CREDITS; i++) begin
            credit_in = 1'b1;
            tick();
        end
        credit_in = 1'b0;
    endtask

    initial begin
        m_locked = 1'b0; m_owner = 0; m_rr = 0; m_cred = CREDITS; m_err = 1'b0;
        flits = 0; min_cred = CREDITS; busy_prev = 1'b0; last_ov = 1'b0;
        rst = 1'b1; req_valid = '0; req_tail = '0; credit_in = 1'b0;
        @(posedge clk); #1;

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("t1_credits", 32'(credits), 32'd4);
        check("t1_busy",    32'(busy),    32'd0);
        check("t1_sel",     32'(sel),     32'd0);

        // Single 3-flit packet on input 2
        flits = 0;
        req_valid = 4'b0100;
        tick();
        check("t2_busy", 32'(busy), 32'd1);
        tick();
        tick();
        req_tail = 4'b0100;
        tick();
        req_valid = '0; req_tail = '0;
        tick();
        check("t2_flits",   32'(flits),   32'd3);
        check("t2_credits", 32'(credits), 32'd1);
        check("t2_idle",    32'(busy),    32'd0);
        refill();

        // All inputs, 1-flit packets, credits returned one cycle after each flit
        rst = 1'b1; tick(); rst = 1'b0;
        grants.delete(); min_cred = CREDITS;
        req_valid = 4'b1111; req_tail = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            credit_in = last_ov;
            tick();
        end
        credit_in = 1'b0;
        check("t3_ngrants", 32'(grants.size()), 32'd5);
        if (grants.size() == 5) begin
            check("t3_g0", 32'(grants[0]), 32'd0);
            check("t3_g1", 32'(grants[1]), 32'd1);
            check("t3_g2", 32'(grants[2]), 32'd2);
            check("t3_g3", 32'(grants[3]), 32'd3);
            check("t3_g4", 32'(grants[4]), 32'd0);
        end
        check("t3_mincred", 32'(min_cred >= 3), 32'd1);
        refill();

        // Credit stall on a 6-flit packet from input 1
        flits = 0;
        req_valid = 4'b0010; req_tail = '0;
        tick();
        for (int i = 0; i < 6; i++) tick();
        check("t4_flits_stall", 32'(flits),   32'd4);
        check("t4_cred0",       32'(credits), 32'd0);
        credit_in = 1'b1; tick();
        credit_in = 1'b0; tick();
        tick();
        check("t4_flits_pulse", 32'(flits), 32'd5);
        credit_in = 1'b1; tick();
        credit_in = 1'b0; req_tail = 4'b0010; tick();
        check("t4_flits_done", 32'(flits), 32'd6);
        refill();

        // Owner bubbles mid-packet while input 3 waits
        req_valid = 4'b0100; req_tail = '0;
        tick();
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) tick();
        check("t5_hold_busy", 32'(busy), 32'd1);
        check("t5_hold_sel",  32'(sel),  32'd2);
        req_valid = 4'b1100; req_tail = 4'b0100;
        tick();
        req_valid = 4'b1000; req_tail = 4'b1000;
        tick();
        check("t5_next_sel",  32'(sel),  32'd3);
        check("t5_next_busy", 32'(busy), 32'd1);
        tick();
        req_valid = '0; req_tail = '0;
        tick();

        // Mid-packet reset on input 0, then a spurious credit
        req_valid = 4'b0001;
        tick();
        tick();
        tick();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; req_valid = '0;
        tick();
        check("t6_busy",    32'(busy),    32'd0);
        check("t6_credits", 32'(credits), 32'd4);
        credit_in = 1'b1; tick();
        credit_in = 1'b0; tick();
        check("t6_err",      32'(credit_err), 32'd1);
        check("t6_cred_sat", 32'(credits),    32'd4);
        req_valid = 4'b1111;
        tick();
        check("t6_rr_sel", 32'(sel), 32'd0);

        // Randomized traffic with well-behaved credit return and occasional reset
        req_valid = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_tail  = 4'($urandom);
            credit_in = (m_cred < CREDITS) && ($urandom % 3 != 0);
            rst       = ($urandom % 64 == 0);
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
